// File: rtl/batch_ctrl_pkg.sv
// Shared types and helpers for the batch filter sequencer.
// Role-bank offsets wrap modulo the four-bank memory cycle.
package batch_ctrl_pkg;

    localparam int N_BANKS = 4;

    typedef logic [1:0] cycle_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    function automatic cycle_t bank_offset(cycle_t c, int k);
        logic [31:0] t;
        t = 32'(c) - 32'(k);
        return t[1:0];
    endfunction

    function automatic int cnt_width(int dd);
        return (dd > 1) ? $clog2(dd) : 1;
    endfunction

endpackage

// File: rtl/batch_cycle_ctrl_if.sv
// Sample-valid input and sequencer status bundle.
// BATCH_CTRL_SYNC_EN adds the sync_req input.
interface batch_cycle_ctrl_if #(
    parameter int CNT_W = 5,
    parameter int NDLY  = 4
) ();
    import batch_ctrl_pkg::*;

    logic                       valid;
`ifdef BATCH_CTRL_SYNC_EN
    logic                       sync_req;
`endif
    logic [CNT_W-1:0]           bat_count;
    logic [CNT_W-1:0]           bat_count_rev;
    cycle_t                     cycle;
    cycle_t                     cycle_lh;
    cycle_t                     cycle_calc;
    cycle_t                     cycle_idle;
    logic                       cycle_pulse;
    logic [NDLY-1:0][CNT_W-1:0] delay_bat_count;
    logic [NDLY-1:0][CNT_W-1:0] delay_bat_count_rev;
    logic [NDLY-1:0][1:0]       delay_cycle;
    logic                       out_valid;

`ifdef BATCH_CTRL_SYNC_EN
    modport master (
        output valid, sync_req,
        input  bat_count, bat_count_rev, cycle, cycle_lh,
        input  cycle_calc, cycle_idle, cycle_pulse,
        input  delay_bat_count, delay_bat_count_rev,
        input  delay_cycle, out_valid
    );
    modport slave (
        input  valid, sync_req,
        output bat_count, bat_count_rev, cycle, cycle_lh,
        output cycle_calc, cycle_idle, cycle_pulse,
        output delay_bat_count, delay_bat_count_rev,
        output delay_cycle, out_valid
    );
`else
    modport master (
        output valid,
        input  bat_count, bat_count_rev, cycle, cycle_lh,
        input  cycle_calc, cycle_idle, cycle_pulse,
        input  delay_bat_count, delay_bat_count_rev,
        input  delay_cycle, out_valid
    );
    modport slave (
        input  valid,
        output bat_count, bat_count_rev, cycle, cycle_lh,
        output cycle_calc, cycle_idle, cycle_pulse,
        output delay_bat_count, delay_bat_count_rev,
        output delay_cycle, out_valid
    );
`endif

endinterface

// File: rtl/batch_delay_line.sv
// Enable-gated shift register aligning values with the LUT/adder pipeline.
// Stage 0 captures the input; stage k holds the value from k enables earlier.
module batch_delay_line #(
    parameter int W = 1,
    parameter int N = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic [W-1:0]        i_d,
    output logic [N-1:0][W-1:0] o_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q[0] <= i_d;
            for (int k = 1; k < N; k++) begin
                o_q[k] <= o_q[k-1];
            end
        end
    end

endmodule

// File: rtl/batch_cycle_ctrl.sv
// Batch sample counter, 4-bank cycle rotation and pipeline-fill sequencer.
// Optional BATCH_CTRL_SYNC_EN: sync_req with valid restarts the batch.
module batch_cycle_ctrl
    import batch_ctrl_pkg::*;
#(
    parameter int DEPTH     = 32,
    parameter int DSR       = 1,
    parameter int LUT_DELAY = 1
) (
    input  logic             clk,
    input  logic             rst,
    batch_cycle_ctrl_if.slave bus
);

    localparam int DOWN_DEPTH = (DEPTH + DSR - 1) / DSR;
    localparam int CNT_W      = cnt_width(DOWN_DEPTH);
    localparam int NDLY       = LUT_DELAY + 3;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DOWN_DEPTH - 1);

    logic [CNT_W-1:0] r_cnt;
    cycle_t           r_cycle;
    logic             r_pulse;
    ctrl_state_t      r_state;
    logic [1:0]       r_fill_cnt;
    logic             r_out_valid;

    logic             w_sync;
    logic             w_last;
    logic [CNT_W-1:0] w_rev;

    logic [NDLY-1:0][CNT_W-1:0] w_dly_cnt;
    logic [NDLY-1:0][CNT_W-1:0] w_dly_rev;
    logic [NDLY-1:0][1:0]       w_dly_cyc;

`ifdef BATCH_CTRL_SYNC_EN
    assign w_sync = bus.valid & bus.sync_req;
`else
    assign w_sync = 1'b0;
`endif

    // Explicit compare keeps non-power-of-2 depths in range.
    assign w_last = (r_cnt == LAST);
    assign w_rev  = LAST - r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_cycle     <= '0;
            r_pulse     <= 1'b0;
            r_state     <= FILL;
            r_fill_cnt  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (w_sync) begin
                r_cnt       <= '0;
                r_cycle     <= r_cycle + 2'd1;
                r_pulse     <= 1'b1;
                r_state     <= FILL;
                r_fill_cnt  <= '0;
                r_out_valid <= 1'b0;
            end else if (bus.valid) begin
                if (w_last) begin
                    r_cnt   <= '0;
                    r_cycle <= r_cycle + 2'd1;
                    r_pulse <= 1'b1;
                    unique case (r_state)
                        FILL: begin
                            r_fill_cnt <= r_fill_cnt + 2'd1;
                            if (r_fill_cnt == 2'd2) begin
                                r_state     <= RUN;
                                r_out_valid <= 1'b1;
                            end
                        end
                        RUN: r_out_valid <= 1'b1;
                        default: r_state <= FILL;
                    endcase
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    batch_delay_line #(.W(CNT_W), .N(NDLY)) u_dly_cnt (
        .clk  (clk),
        .rst  (rst),
        .i_en (bus.valid),
        .i_d  (r_cnt),
        .o_q  (w_dly_cnt)
    );

    batch_delay_line #(.W(CNT_W), .N(NDLY)) u_dly_rev (
        .clk  (clk),
        .rst  (rst),
        .i_en (bus.valid),
        .i_d  (w_rev),
        .o_q  (w_dly_rev)
    );

    batch_delay_line #(.W(2), .N(NDLY)) u_dly_cyc (
        .clk  (clk),
        .rst  (rst),
        .i_en (bus.valid),
        .i_d  (r_cycle),
        .o_q  (w_dly_cyc)
    );

    assign bus.bat_count           = r_cnt;
    assign bus.bat_count_rev       = w_rev;
    assign bus.cycle               = r_cycle;
    assign bus.cycle_lh            = bank_offset(r_cycle, 1);
    assign bus.cycle_calc          = bank_offset(r_cycle, 2);
    assign bus.cycle_idle          = bank_offset(r_cycle, 3);
    assign bus.cycle_pulse         = r_pulse;
    assign bus.delay_bat_count     = w_dly_cnt;
    assign bus.delay_bat_count_rev = w_dly_rev;
    assign bus.delay_cycle         = w_dly_cyc;
    assign bus.out_valid           = r_out_valid;

endmodule

// File: tb/tb_batch_cycle_ctrl.sv
// Scoreboard bench for batch_cycle_ctrl (DEPTH=32/DSR=1 and DEPTH=30/DSR=4).
// Honours BATCH_CTRL_SYNC_EN when defined.
module tb_batch_cycle_ctrl;

    localparam int NDLY = 4;
    localparam int DD1  = 32;
    localparam int DD2  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    batch_cycle_ctrl_if #(.CNT_W(5), .NDLY(NDLY)) bus1 ();
    batch_cycle_ctrl_if #(.CNT_W(3), .NDLY(NDLY)) bus2 ();

    batch_cycle_ctrl #(.DEPTH(32), .DSR(1), .LUT_DELAY(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    batch_cycle_ctrl #(.DEPTH(30), .DSR(4), .LUT_DELAY(1)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        int cnt, rev, cyc, lh, calc, idle, pulse, ov;
        int dcnt[NDLY];
        int drev[NDLY];
        int dcyc[NDLY];
        int cnt2, rev2, cyc2;
    } exp_t;

    exp_t q[$];

    int tests = 0;
    int fails = 0;
    int pulses_seen = 0;

    int m_cnt, m_cyc, m_wraps, m_pulse;
    int m_dcnt[NDLY];
    int m_drev[NDLY];
    int m_dcyc[NDLY];
    int m2_cnt, m2_cyc;

    task automatic chk(string tag, logic [31:0] obs, int exp);
        tests++;
        assert (obs === 32'(exp)) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_cyc = 0; m_wraps = 0; m_pulse = 0;
        m2_cnt = 0; m2_cyc = 0;
        for (int k = 0; k < NDLY; k++) begin
            m_dcnt[k] = 0; m_drev[k] = 0; m_dcyc[k] = 0;
        end
    endtask

    task automatic cyc(bit v, bit s);
        exp_t e;
        bit do_sync;
        @(negedge clk);
        bus1.valid = v;
        bus2.valid = v;
`ifdef BATCH_CTRL_SYNC_EN
        bus1.sync_req = s;
        bus2.sync_req = 1'b0;
        do_sync = v & s;
`else
        do_sync = 1'b0 & s;
`endif
        if (v) begin
            for (int k = NDLY - 1; k > 0; k--) begin
                m_dcnt[k] = m_dcnt[k-1];
                m_drev[k] = m_drev[k-1];
                m_dcyc[k] = m_dcyc[k-1];
            end
            m_dcnt[0] = m_cnt;
            m_drev[0] = DD1 - 1 - m_cnt;
            m_dcyc[0] = m_cyc;
        end
        m_pulse = 0;
        if (do_sync) begin
            m_cnt = 0; m_cyc = (m_cyc + 1) % 4;
            m_pulse = 1; m_wraps = 0;
        end else if (v) begin
            if (m_cnt == DD1 - 1) begin
                m_cnt = 0; m_cyc = (m_cyc + 1) % 4;
                m_pulse = 1;
                if (m_wraps < 3) m_wraps++;
            end else begin
                m_cnt++;
            end
        end
        if (v) begin
            if (m2_cnt == DD2 - 1) begin
                m2_cnt = 0; m2_cyc = (m2_cyc + 1) % 4;
            end else begin
                m2_cnt++;
            end
        end
        e.cnt = m_cnt; e.rev = DD1 - 1 - m_cnt; e.cyc = m_cyc;
        e.lh = (m_cyc + 3) % 4; e.calc = (m_cyc + 2) % 4;
        e.idle = (m_cyc + 1) % 4;
        e.pulse = m_pulse; e.ov = (m_wraps >= 3) ? 1 : 0;
        e.dcnt = m_dcnt; e.drev = m_drev; e.dcyc = m_dcyc;
        e.cnt2 = m2_cnt; e.rev2 = DD2 - 1 - m2_cnt; e.cyc2 = m2_cyc;
        q.push_back(e);

        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("bat_count", 32'(bus1.bat_count), e.cnt);
        chk("bat_count_rev", 32'(bus1.bat_count_rev), e.rev);
        chk("cycle", 32'(bus1.cycle), e.cyc);
        chk("cycle_lh", 32'(bus1.cycle_lh), e.lh);
        chk("cycle_calc", 32'(bus1.cycle_calc), e.calc);
        chk("cycle_idle", 32'(bus1.cycle_idle), e.idle);
        chk("cycle_pulse", 32'(bus1.cycle_pulse), e.pulse);
        chk("out_valid", 32'(bus1.out_valid), e.ov);
        for (int k = 0; k < NDLY; k++) begin
            chk($sformatf("delay_cnt%0d", k),
                32'(bus1.delay_bat_count[k]), e.dcnt[k]);
            chk($sformatf("delay_rev%0d", k),
                32'(bus1.delay_bat_count_rev[k]), e.drev[k]);
            chk($sformatf("delay_cyc%0d", k),
                32'(bus1.delay_cycle[k]), e.dcyc[k]);
        end
        chk("d8_count", 32'(bus2.bat_count), e.cnt2);
        chk("d8_rev", 32'(bus2.bat_count_rev), e.rev2);
        chk("d8_cycle", 32'(bus2.cycle), e.cyc2);
        if (bus1.cycle_pulse === 1'b1) pulses_seen++;
    endtask

    initial begin
        bus1.valid = 1'b0;
        bus2.valid = 1'b0;
`ifdef BATCH_CTRL_SYNC_EN
        bus1.sync_req = 1'b0;
        bus2.sync_req = 1'b0;
`endif
        model_reset();
        rst = 1'b1;
        #2;
        chk("rst_count", 32'(bus1.bat_count), 0);
        chk("rst_rev", 32'(bus1.bat_count_rev), 31);
        chk("rst_cycle", 32'(bus1.cycle), 0);
        chk("rst_lh", 32'(bus1.cycle_lh), 3);
        chk("rst_pulse", 32'(bus1.cycle_pulse), 0);
        chk("rst_out_valid", 32'(bus1.out_valid), 0);
        chk("rst_d8_count", 32'(bus2.bat_count), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        for (int i = 0; i < 64; i++) cyc(1'b1, 1'b0);
        chk("pulses_at_96", 32'(pulses_seen), 3);
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b0);
        chk("pulses_at_128", 32'(pulses_seen), 4);

        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b0);
            cyc(1'b0, 1'b0);
            cyc(1'b1, 1'b0);
        end
        for (int i = 0; i < 41; i++) cyc(1'b1, 1'b0);
        chk("pre_rst_count", 32'(bus1.bat_count), 17);
        chk("pre_rst_cycle", 32'(bus1.cycle), 2);
        chk("pre_rst_out_valid", 32'(bus1.out_valid), 1);

        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(bus1.bat_count), 0);
        chk("arst_cycle", 32'(bus1.cycle), 0);
        chk("arst_pulse", 32'(bus1.cycle_pulse), 0);
        chk("arst_out_valid", 32'(bus1.out_valid), 0);
        for (int k = 0; k < NDLY; k++) begin
            chk($sformatf("arst_delay_cnt%0d", k),
                32'(bus1.delay_bat_count[k]), 0);
            chk($sformatf("arst_delay_cyc%0d", k),
                32'(bus1.delay_cycle[k]), 0);
        end
        model_reset();
        bus1.valid = 1'b0;
        bus2.valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 95; i++) cyc(1'b1, 1'b0);
        chk("refill_95", 32'(bus1.out_valid), 0);
        cyc(1'b1, 1'b0);
        chk("refill_96", 32'(bus1.out_valid), 1);

        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
        chk("sync_at_10", 32'(bus1.bat_count), 10);
        cyc(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/batch_cycle_ctrl.md
Name: batch_cycle_ctrl

Overview:
- Sequencer for the fixed-point batch filter datapath.
- Generates the batch sample counter (forward and reverse) and rotates the 4-bank memory cycle index.
- Derives per-role bank selects (write, lookahead, calc, idle) and the one-clock cyclePulse.
- Drives the LUT/adder pipeline-aligned delayed copies of counter and cycle consumed by result memories, plus the pipeline-fill status.

Parameters:
- DEPTH, 32, filter batch depth in input samples.
- DSR, 1, downsample ratio; DOWN_DEPTH = ceil(DEPTH/DSR).
- LUT_DELAY, 1, LUT/adder pipeline stages; delay chain length is LUT_DELAY+3.
- Derived localparam CNT_W = $clog2(DOWN_DEPTH), minimum 1.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- valid  in  1  one downsampled sample accepted this clock.
- bat_count  out  CNT_W  forward index within batch.
- bat_count_rev  out  CNT_W  DOWN_DEPTH-1-bat_count.
- cycle  out  2  write bank.
- cycle_lh  out  2  lookahead bank = cycle-1 mod 4.
- cycle_calc  out  2  calc bank = cycle-2 mod 4.
- cycle_idle  out  2  idle bank = cycle-3 mod 4.
- cycle_pulse  out  1  high exactly one clk after a batch wrap.
- delay_bat_count  out  CNT_W x (LUT_DELAY+3)  delayed bat_count chain.
- delay_bat_count_rev  out  CNT_W x (LUT_DELAY+3)  delayed reverse chain.
- delay_cycle  out  2 x (LUT_DELAY+3)  delayed cycle chain.
- out_valid  out  1  pipeline filled; results meaningful.

Behaviour:
- Reset (async, any time, including mid-batch): bat_count=0, cycle=0, cycle_pulse=0, all delay entries=0, fill_cnt=0, state=FILL, out_valid=0. Reset release takes effect on the next posedge.
- valid=0: every register holds, except cycle_pulse, which clears the next clock.
- valid=1:
  - If bat_count != DOWN_DEPTH-1: bat_count += 1.
  - Otherwise: bat_count <= 0, cycle <= cycle+1 (2-bit wrap 3→0), cycle_pulse <= 1.
- Wrap is an explicit compare, so a non-power-of-2 DOWN_DEPTH never reaches an out-of-range count.
- bat_count_rev and the role banks are combinational from registered state. Zero added latency.
- Delay chain, on valid only: delay_x[0] <= x (current pre-update value); delay_x[k] <= delay_x[k-1] for k=1..LUT_DELAY+2.
- FSM:
  - FILL: on each wrap, fill_cnt += 1. When a wrap occurs with fill_cnt==2, go to RUN.
  - RUN: out_valid=1. Stays in RUN until reset.
  - out_valid rises on the same edge as the 3rd cycle_pulse.
- Simultaneous wrap and cycle_pulse-clear: the new wrap wins, so cycle_pulse stays 1. This only happens when DOWN_DEPTH=1.
- DOWN_DEPTH=1: every valid is a wrap.
- All outputs are registered or derived from registers. No combinational path from valid to outputs.

Optional Feature:
- Macro: BATCH_CTRL_SYNC_EN.
- Defined: adds input sync_req (1 bit).
  - sync_req=1 with valid=1 forces bat_count=0, advances cycle, asserts cycle_pulse, and returns the FSM to FILL with fill_cnt=0 and out_valid=0.
  - The delay chain shifts normally.
  - sync_req with valid=0 is ignored.
- Undefined: no port and no logic; behaviour is exactly as above.

Decomposition:
- Shared package batch_ctrl_pkg:
  - typedef cycle_t (logic[1:0]).
  - enum ctrl_state_t {FILL, RUN}.
  - Constant N_BANKS=4 and function bank_offset(cycle_t c, int k) returning (c-k) mod 4.
- One natural sub-module: batch_delay_line. Parameterized width and stage count, enable-gated shift register with async reset. Instantiated three times for bat_count, bat_count_rev and cycle.

Test Plan:
- DEPTH=32, DSR=1: assert rst, release, then 32 consecutive valids → bat_count 0..31, bat_count_rev 31..0; after the 32nd valid, bat_count=0, cycle=1, cycle_pulse=1 for one clk, cycle_lh=0, cycle_calc=3, cycle_idle=2.
- 96 consecutive valids → cycle_pulse seen 3 times, cycle=3, out_valid rises on the 96th-valid edge; 128 valids → cycle=0 (wrap).
- Valid every 3rd clock for 40 samples → bat_count advances only on valid, wrap at sample 32, cycle_pulse width exactly 1 clk, delay_bat_count[k] equals bat_count from k+1 valids earlier.
- DEPTH=30, DSR=4 (DOWN_DEPTH=8, CNT_W=3) → count 0..7 then 0; bat_count_rev 7..0; never exceeds 7.
- Async rst pulse mid-clock at bat_count=17, cycle=2 in RUN → all outputs 0 immediately without a clock edge, out_valid=0, refill needs 3 more wraps.
- With BATCH_CTRL_SYNC_EN defined, sync_req+valid at bat_count=10 → bat_count=0, cycle+1, cycle_pulse=1, out_valid=0. Without the macro, the same stimulus minus the port leaves counting uninterrupted.
